alu_arbiter: RTL and testbench

//   Shares one combinational alu instance between NREQ requesters.

---
 rtl/alu_pkg.sv | 32 +++
 rtl/alu.sv | 37 +++
 rtl/alu_arbiter.sv | 144 ++++++++++++++
 tb/tb_alu_arbiter.sv | 199 +++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared definitions for the ALU and its requester arbiter.
//   command_t : 4-bit ALU operation code (encodings 14 and 15 are undefined)
//   XLEN      : operand/result width of the ALU datapath
//   arb_state_t : arbiter FSM state encoding
package alu_pkg;

    localparam int XLEN = 32;

    typedef enum logic [3:0] {
        ADD  = 4'd0,
        SUB  = 4'd1,
        AND  = 4'd2,
        OR   = 4'd3,
        XOR  = 4'd4,
        SLL  = 4'd5,
        SRL  = 4'd6,
        SRA  = 4'd7,
        EQ   = 4'd8,
        NE   = 4'd9,
        LT   = 4'd10,
        LTU  = 4'd11,
        GE   = 4'd12,
        GEU  = 4'd13
    } command_t;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_RESP = 2'd2
    } arb_state_t;

endpackage

// File: rtl/alu.sv
// Purely combinational ALU.
//   command_i : operation select (command_t)
//   lhs_i     : left operand
//   rhs_i     : right operand (shifts use the full value as the amount)
//   res_o     : result; comparisons return 0/1, undefined commands return 0
module alu
    import alu_pkg::*;
(
    input  command_t          command_i,
    input  logic [XLEN-1:0]   lhs_i,
    input  logic [XLEN-1:0]   rhs_i,
    output logic [XLEN-1:0]   res_o
);

    always_comb begin
        res_o = '0;
        case (command_i)
            ADD: res_o = lhs_i + rhs_i;
            SUB: res_o = lhs_i - rhs_i;
            AND: res_o = lhs_i & rhs_i;
            OR:  res_o = lhs_i | rhs_i;
            XOR: res_o = lhs_i ^ rhs_i;
            // Shift amounts of XLEN or more flush the value (sign-fill for SRA).
            SLL: res_o = lhs_i << rhs_i;
            SRL: res_o = lhs_i >> rhs_i;
            SRA: res_o = $signed(lhs_i) >>> rhs_i;
            EQ:  res_o = {{(XLEN-1){1'b0}}, (lhs_i == rhs_i)};
            NE:  res_o = {{(XLEN-1){1'b0}}, (lhs_i != rhs_i)};
            LT:  res_o = {{(XLEN-1){1'b0}}, ($signed(lhs_i) <  $signed(rhs_i))};
            LTU: res_o = {{(XLEN-1){1'b0}}, (lhs_i <  rhs_i)};
            GE:  res_o = {{(XLEN-1){1'b0}}, ($signed(lhs_i) >= $signed(rhs_i))};
            GEU: res_o = {{(XLEN-1){1'b0}}, (lhs_i >= rhs_i)};
            default: res_o = '0;
        endcase
    end

endmodule

// File: rtl/alu_arbiter.sv
// Round-robin arbiter sharing one ALU between NREQ requesters.
//   clk, rst    : clock, synchronous active-high reset
//   req_valid   : per-requester request present
//   req_ready   : one-hot grant (only in IDLE, never during reset)
//   req_command : packed command_t per requester, [4*i+3:4*i]
//   req_lhs/rhs : packed XLEN-bit operands per requester
//   rsp_valid   : result available
//   rsp_ready   : consumer accepts the result
//   rsp_id      : index of the requester that issued the result
//   rsp_res     : ALU result
//   busy        : high whenever the FSM is not IDLE
// Handshake: a transfer occurs on a rising edge where valid and ready are both
// high; the producer holds its payload stable while valid is high and not ready.
module alu_arbiter #(
    parameter int NREQ = 2,
    parameter int XLEN = alu_pkg::XLEN,
    localparam int IDW = (NREQ > 1) ? $clog2(NREQ) : 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NREQ-1:0]      req_valid,
    output logic [NREQ-1:0]      req_ready,
    input  logic [NREQ*4-1:0]    req_command,
    input  logic [NREQ*XLEN-1:0] req_lhs,
    input  logic [NREQ*XLEN-1:0] req_rhs,
    output logic                 rsp_valid,
    input  logic                 rsp_ready,
    output logic [IDW-1:0]       rsp_id,
    output logic [XLEN-1:0]      rsp_res,
    output logic                 busy
);

    import alu_pkg::*;

    // Returns {found, index} of the first valid requester at or after ptr,
    // wrapping modulo NREQ. Scanning from the far end lets the nearest win.
    function automatic logic [IDW:0] rr_pick(input logic [NREQ-1:0] v,
                                             input logic [IDW-1:0]  ptr);
        logic [IDW:0] r;
        int           idx;
        r = '0;
        for (int k = NREQ - 1; k >= 0; k--) begin
            idx = (int'(ptr) + k) % NREQ;
            if (v[idx]) r = {1'b1, IDW'(idx)};
        end
        return r;
    endfunction

    arb_state_t       state_q,     state_d;
    logic [IDW-1:0]   rr_ptr_q,    rr_ptr_d;
    command_t         cmd_q,       cmd_d;
    logic [XLEN-1:0]  lhs_q,       lhs_d;
    logic [XLEN-1:0]  rhs_q,       rhs_d;
    logic [IDW-1:0]   gid_q,       gid_d;
    logic             rsp_valid_q, rsp_valid_d;
    logic [IDW-1:0]   rsp_id_q,    rsp_id_d;
    logic [XLEN-1:0]  rsp_res_q,   rsp_res_d;

    logic [IDW:0]     pick;
    logic             found;
    logic [IDW-1:0]   gnt_idx;
    logic [XLEN-1:0]  alu_res;

    assign pick    = rr_pick(req_valid, rr_ptr_q);
    assign found   = pick[IDW];
    assign gnt_idx = pick[IDW-1:0];

    alu u_alu (
        .command_i (cmd_q),
        .lhs_i     (lhs_q),
        .rhs_i     (rhs_q),
        .res_o     (alu_res)
    );

    always_comb begin
        state_d     = state_q;
        rr_ptr_d    = rr_ptr_q;
        cmd_d       = cmd_q;
        lhs_d       = lhs_q;
        rhs_d       = rhs_q;
        gid_d       = gid_q;
        rsp_valid_d = rsp_valid_q;
        rsp_id_d    = rsp_id_q;
        rsp_res_d   = rsp_res_q;
        req_ready   = '0;
        case (state_q)
            ST_IDLE: begin
                if (found) begin
                    // Ready is gated by reset so no transfer is advertised then.
                    req_ready[gnt_idx] = !rst;
                    state_d  = ST_EXEC;
                    cmd_d    = command_t'(req_command[4*gnt_idx +: 4]);
                    lhs_d    = req_lhs[XLEN*gnt_idx +: XLEN];
                    rhs_d    = req_rhs[XLEN*gnt_idx +: XLEN];
                    gid_d    = gnt_idx;
                    rr_ptr_d = (gnt_idx == IDW'(NREQ - 1)) ? '0 : gnt_idx + 1'b1;
                end
            end
            ST_EXEC: begin
                rsp_res_d   = alu_res;
                rsp_id_d    = gid_q;
                rsp_valid_d = 1'b1;
                state_d     = ST_RESP;
            end
            ST_RESP: begin
                if (rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    state_d     = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            rr_ptr_q    <= '0;
            cmd_q       <= ADD;
            lhs_q       <= '0;
            rhs_q       <= '0;
            gid_q       <= '0;
            rsp_valid_q <= 1'b0;
            rsp_id_q    <= '0;
            rsp_res_q   <= '0;
        end else begin
            state_q     <= state_d;
            rr_ptr_q    <= rr_ptr_d;
            cmd_q       <= cmd_d;
            lhs_q       <= lhs_d;
            rhs_q       <= rhs_d;
            gid_q       <= gid_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_id_q    <= rsp_id_d;
            rsp_res_q   <= rsp_res_d;
        end
    end

    assign rsp_valid = rsp_valid_q;
    assign rsp_id    = rsp_id_q;
    assign rsp_res   = rsp_res_q;
    assign busy      = (state_q != ST_IDLE);

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed bench for alu_arbiter with NREQ=2. Inputs change just after the
// falling edge; outputs are sampled at the falling edge (or #1 after it).
module tb_alu_arbiter;
    import alu_pkg::*;

    localparam int NREQ = 2;
    localparam int W    = 32;
    localparam int IDW  = 1;

    logic                clk = 1'b0;
    logic                rst;
    logic [NREQ-1:0]     req_valid;
    logic [NREQ-1:0]     req_ready;
    logic [NREQ*4-1:0]   req_command;
    logic [NREQ*W-1:0]   req_lhs;
    logic [NREQ*W-1:0]   req_rhs;
    logic                rsp_valid;
    logic                rsp_ready;
    logic [IDW-1:0]      rsp_id;
    logic [W-1:0]        rsp_res;
    logic                busy;

    int n_cmp = 0;
    int n_err = 0;

    alu_arbiter #(.NREQ(NREQ), .XLEN(W)) dut (
        .clk         (clk),
        .rst         (rst),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .req_command (req_command),
        .req_lhs     (req_lhs),
        .req_rhs     (req_rhs),
        .rsp_valid   (rsp_valid),
        .rsp_ready   (rsp_ready),
        .rsp_id      (rsp_id),
        .rsp_res     (rsp_res),
        .busy        (busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic set_req(input int i, input logic v, input logic [3:0] c,
                           input logic [W-1:0] a, input logic [W-1:0] b);
        req_valid[i]          = v;
        req_command[4*i +: 4] = c;
        req_lhs[W*i +: W]     = a;
        req_rhs[W*i +: W]     = b;
    endtask

    task automatic wait_rsp(input int max_cyc, output bit got);
        got = 1'b0;
        for (int i = 0; i < max_cyc && !got; i++) begin
            @(negedge clk);
            if (rsp_valid === 1'b1) got = 1'b1;
        end
    endtask

    initial begin
        bit got;
        int nrsp;
        int last_cyc;

        // 1. Reset held three cycles with every requester valid
        rst         = 1'b1;
        rsp_ready   = 1'b0;
        req_valid   = '0;
        req_command = '0;
        req_lhs     = '0;
        req_rhs     = '0;
        set_req(0, 1'b1, ADD, 32'd1, 32'd1);
        set_req(1, 1'b1, ADD, 32'd2, 32'd2);
        @(posedge clk);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("rst_ready", W'(req_ready), 32'd0);
            chk("rst_rsp_valid", W'(rsp_valid), 32'd0);
            chk("rst_busy", W'(busy), 32'd0);
        end
        chk("rst_rsp_id", W'(rsp_id), 32'd0);
        chk("rst_rsp_res", rsp_res, 32'd0);
        rst       = 1'b0;
        req_valid = '0;
        @(negedge clk);

        // 2. Single ADD 5+7 from requester 0
        set_req(0, 1'b1, ADD, 32'd5, 32'd7);
        rsp_ready = 1'b1;
        #1 chk("add_ready", W'(req_ready), 32'b01);
        @(negedge clk);
        set_req(0, 1'b0, ADD, 32'd0, 32'd0);
        chk("add_exec_busy", W'(busy), 32'd1);
        chk("add_exec_valid", W'(rsp_valid), 32'd0);
        chk("add_exec_ready", W'(req_ready), 32'd0);
        @(negedge clk);
        chk("add_valid", W'(rsp_valid), 32'd1);
        chk("add_id", W'(rsp_id), 32'd0);
        chk("add_res", rsp_res, 32'd12);
        @(negedge clk);
        chk("add_one_wide", W'(rsp_valid), 32'd0);
        chk("add_idle_busy", W'(busy), 32'd0);

        // Short reset so the rotation restarts at requester 0
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;

        // 3. Round-robin with both requesters continuously valid
        set_req(0, 1'b1, SUB, 32'd10, 32'd3);
        set_req(1, 1'b1, SRA, 32'h8000_0000, 32'd4);
        nrsp     = 0;
        last_cyc = 0;
        for (int cyc = 0; cyc < 30 && nrsp < 4; cyc++) begin
            @(negedge clk);
            if (rsp_valid === 1'b1) begin
                chk("rr_id", W'(rsp_id), W'(nrsp % 2));
                chk("rr_res", rsp_res, (nrsp % 2 == 0) ? 32'd7 : 32'hF800_0000);
                if (nrsp > 0) chk("rr_interval", W'(cyc - last_cyc), 32'd3);
                last_cyc = cyc;
                nrsp++;
                if (nrsp == 4) req_valid = '0;
            end
        end
        chk("rr_count", W'(nrsp), 32'd4);
        @(negedge clk);
        chk("rr_drained", W'(rsp_valid), 32'd0);

        // 4. Backpressure on a signed LT -1 < 1
        set_req(0, 1'b1, LT, 32'hFFFF_FFFF, 32'd1);
        rsp_ready = 1'b0;
        @(negedge clk);
        set_req(0, 1'b0, ADD, 32'd0, 32'd0);
        set_req(1, 1'b1, ADD, 32'd1, 32'd1);
        @(negedge clk);
        for (int i = 0; i < 5; i++) begin
            chk("bp_valid", W'(rsp_valid), 32'd1);
            chk("bp_res", rsp_res, 32'd1);
            chk("bp_id", W'(rsp_id), 32'd0);
            chk("bp_ready", W'(req_ready), 32'd0);
            chk("bp_busy", W'(busy), 32'd1);
            @(negedge clk);
        end
        req_valid = '0;
        rsp_ready = 1'b1;
        chk("bp_last_valid", W'(rsp_valid), 32'd1);
        @(negedge clk);
        chk("bp_released", W'(rsp_valid), 32'd0);
        chk("bp_idle", W'(busy), 32'd0);

        // 5. Reset during EXEC discards the operation
        set_req(0, 1'b1, GEU, 32'd3, 32'd3);
        #1 chk("mid_ready_single", W'(req_ready), 32'b01);
        @(negedge clk);
        chk("mid_exec_busy", W'(busy), 32'd1);
        rst = 1'b1;
        set_req(0, 1'b0, ADD, 32'd0, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        chk("mid_idle", W'(busy), 32'd0);
        chk("mid_ready", W'(req_ready), 32'd0);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("mid_no_rsp", W'(rsp_valid), 32'd0);
        end

        // 6. Undefined command then EQ 9,9
        set_req(1, 1'b1, 4'hF, 32'd1, 32'd1);
        #1 chk("undef_ready", W'(req_ready), 32'b10);
        @(negedge clk);
        set_req(1, 1'b0, ADD, 32'd0, 32'd0);
        wait_rsp(5, got);
        chk("undef_timeout", W'(got), 32'd1);
        chk("undef_res", rsp_res, 32'd0);
        chk("undef_id", W'(rsp_id), 32'd1);
        @(negedge clk);
        set_req(0, 1'b1, EQ, 32'd9, 32'd9);
        #1 chk("eq_ready", W'(req_ready), 32'b01);
        @(negedge clk);
        set_req(0, 1'b0, ADD, 32'd0, 32'd0);
        wait_rsp(5, got);
        chk("eq_timeout", W'(got), 32'd1);
        chk("eq_res", rsp_res, 32'd1);
        chk("eq_id", W'(rsp_id), 32'd0);
        @(negedge clk);
        chk("eq_done", W'(rsp_valid), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
